// File: rtl/painel_producao_if.sv
// painel_producao_if: groups the production-panel event inputs and the
// display/status outputs into one bundle.
//   master : line side, drives the event pulses and reads display/flags
//   slave  : panel side (painel_producao)
// Parameter DIG_GAR sets the lot digit count; dig is DIG_GAR+2 bits wide.
interface painel_producao_if #(
   parameter int DIG_GAR = 2
);
   logic                 gar_completa;
   logic                 rolha_usada;
   logic                 reset_duzias;
   logic                 reset_rolhas;
   logic                 pedido_recarga;
   logic [6:0]           seg;
   logic [DIG_GAR+1:0]   dig;
   logic                 tem_rec;
   logic                 rolha_baixa;
   logic                 rolha_vazia;
   logic                 estouro;

   modport master (
      output gar_completa, rolha_usada, reset_duzias, reset_rolhas, pedido_recarga,
      input  seg, dig, tem_rec, rolha_baixa, rolha_vazia, estouro
   );

   modport slave (
      input  gar_completa, rolha_usada, reset_duzias, reset_rolhas, pedido_recarga,
      output seg, dig, tem_rec, rolha_baixa, rolha_vazia, estouro
   );
endinterface

// File: rtl/painel_producao.sv
// painel_producao: bottling-line production panel.
//   - counts finished bottles in lots of GAR_POR_LOTE on a DIG_GAR-digit BCD
//     counter (sticky estouro on wrap)
//   - tracks cork stock (0..ROLHA_CAP) with RECARGAS magazine refills
//   - multiplexes lot digits (MSB first) then stock tens/units onto a
//     7-segment display, each digit active SCAN_DIV clk cycles
// Ports:
//   clk   : clock, all state on rising edge
//   reset : synchronous active-high full reset
//   bus   : painel_producao_if.slave (event pulses in; seg/dig/flags out)
// Optional feature macro: RECARGA_AUTO_EN -- when defined, an empty stock
// with refills left is refilled automatically on the next edge.
module painel_producao #(
   parameter int DIG_GAR      = 2,
   parameter int GAR_POR_LOTE = 12,
   parameter int ROLHA_CAP    = 20,
   parameter int ROLHA_LIMIAR = 5,
   parameter int RECARGAS     = 5,
   parameter int SCAN_DIV     = 1000
) (
   input  logic              clk,
   input  logic              reset,
   painel_producao_if.slave  bus
);

   localparam int NDIG = DIG_GAR + 2;
   localparam int IW   = $clog2(NDIG);
   localparam int PW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   // bottle / lot state
   logic [3:0]      gar, gar_n;
   logic [3:0]      lot   [DIG_GAR];
   logic [3:0]      lot_n [DIG_GAR];
   logic            estouro_q, estouro_n;
   logic            carry;

   // cork state
   logic [6:0]      stock, stock_n;
   logic [2:0]      rec, rec_n;
   logic            refill_ok, auto_ok;

   // display state
   logic [PW-1:0]   presc, presc_n;
   logic [IW-1:0]   idx, idx_n;
   logic            presc_tc;
   logic [3:0]      cur, tens, units;
   logic [6:0]      seg_q, seg_n;
   logic [NDIG-1:0] dig_q, dig_n;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b0111111;
         4'd1:    seg7 = 7'b0000110;
         4'd2:    seg7 = 7'b1011011;
         4'd3:    seg7 = 7'b1001111;
         4'd4:    seg7 = 7'b1100110;
         4'd5:    seg7 = 7'b1101101;
         4'd6:    seg7 = 7'b1111101;
         4'd7:    seg7 = 7'b0000111;
         4'd8:    seg7 = 7'b1111111;
         4'd9:    seg7 = 7'b1101111;
         default: seg7 = 7'b0000000;
      endcase
   endfunction

   // Bottle counter and ripple-carry BCD lot counter
   always_comb begin
      gar_n     = gar;
      estouro_n = estouro_q;
      carry     = 1'b0;
      for (int unsigned i = 0; i < DIG_GAR; i++) lot_n[i] = lot[i];
      if (bus.reset_duzias) begin
         gar_n     = '0;
         estouro_n = 1'b0;
         for (int unsigned i = 0; i < DIG_GAR; i++) lot_n[i] = '0;
      end else if (bus.gar_completa) begin
         if (gar == 4'(GAR_POR_LOTE - 1)) begin
            gar_n = '0;
            carry = 1'b1;
            for (int unsigned i = 0; i < DIG_GAR; i++) begin
               if (carry) begin
                  if (lot[i] == 4'd9) begin
                     lot_n[i] = '0;
                  end else begin
                     lot_n[i] = lot[i] + 4'd1;
                     carry    = 1'b0;
                  end
               end
            end
            // carry out of the top digit means every digit was 9
            if (carry) estouro_n = 1'b1;
         end else begin
            gar_n = gar + 4'd1;
         end
      end
   end

   // Cork stock and refills
   always_comb begin
      stock_n   = stock;
      rec_n     = rec;
      refill_ok = (rec != '0) && (stock <= 7'(ROLHA_LIMIAR));
`ifdef RECARGA_AUTO_EN
      auto_ok   = (stock == '0) && (rec != '0);
`else
      auto_ok   = 1'b0;
`endif
      if (bus.reset_rolhas) begin
         stock_n = 7'(ROLHA_CAP);
         rec_n   = 3'(RECARGAS);
      end else if ((bus.pedido_recarga && refill_ok) || auto_ok) begin
         // a cork used in the refill cycle comes out of the new magazine
         stock_n = bus.rolha_usada ? 7'(ROLHA_CAP - 1) : 7'(ROLHA_CAP);
         rec_n   = rec - 3'd1;
      end else if (bus.rolha_usada && (stock != '0)) begin
         stock_n = stock - 7'd1;
      end
   end

   // Display scan: prescaler, digit index, digit select and decode
   always_comb begin
      presc_tc = (presc == PW'(SCAN_DIV - 1));
      presc_n  = presc_tc ? '0 : presc + PW'(1);
      idx_n    = idx;
      if (presc_tc) idx_n = (idx == IW'(NDIG - 1)) ? '0 : idx + IW'(1);

      tens  = 4'(stock / 7'd10);
      units = 4'(stock % 7'd10);
      cur   = '0;
      if (idx == IW'(DIG_GAR)) begin
         cur = tens;
      end else if (idx == IW'(DIG_GAR + 1)) begin
         cur = units;
      end else begin
         for (int unsigned i = 0; i < DIG_GAR; i++)
            if (idx == IW'(i)) cur = lot[DIG_GAR - 1 - i];
      end
      seg_n = seg7(cur);
      dig_n = ~(NDIG'(1) << idx);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         gar       <= '0;
         estouro_q <= 1'b0;
         for (int unsigned i = 0; i < DIG_GAR; i++) lot[i] <= '0;
         stock     <= 7'(ROLHA_CAP);
         rec       <= 3'(RECARGAS);
         presc     <= '0;
         idx       <= '0;
         seg_q     <= 7'b0111111;
         dig_q     <= ~NDIG'(1);
      end else begin
         gar       <= gar_n;
         estouro_q <= estouro_n;
         for (int unsigned i = 0; i < DIG_GAR; i++) lot[i] <= lot_n[i];
         stock     <= stock_n;
         rec       <= rec_n;
         presc     <= presc_n;
         idx       <= idx_n;
         seg_q     <= seg_n;
         dig_q     <= dig_n;
      end
   end

   assign bus.seg         = seg_q;
   assign bus.dig         = dig_q;
   assign bus.estouro     = estouro_q;
   assign bus.tem_rec     = (rec != '0);
   assign bus.rolha_baixa = (stock != '0) && (stock <= 7'(ROLHA_LIMIAR));
   assign bus.rolha_vazia = (stock == '0);

endmodule
